// File: rtl/fifo_byte_unpacker.sv
// fifo_byte_unpacker: pulls one word at a time from a sync_fifo and streams it out as bytes
module fifo_byte_unpacker #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter bit LSB_FIRST  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    input  logic                  fifo_rd_data_valid_i,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    output logic                  byte_valid_o,
    input  logic                  byte_ready_i,
    output logic [BYTE_WIDTH-1:0] byte_data_o,
    output logic                  byte_last_o,
    output logic [15:0]           word_cnt_o
);
    localparam int N = DATA_WIDTH / BYTE_WIDTH;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] PEN_IDX = IW'(N - 2);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, SEND} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] sr;
    logic [IW-1:0]         idx;

    // The byte being offered always sits at the exit end of the shift register
    assign byte_data_o = LSB_FIRST ? sr[BYTE_WIDTH-1:0] : sr[DATA_WIDTH-1 -: BYTE_WIDTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            sr           <= '0;
            idx          <= '0;
            word_cnt_o   <= '0;
            fifo_rd_en_o <= 1'b0;
            byte_valid_o <= 1'b0;
            byte_last_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty_i) begin
                        state        <= REQ;
                        fifo_rd_en_o <= 1'b1;
                    end
                end
                REQ: begin
                    state        <= WAIT;
                    fifo_rd_en_o <= 1'b0;
                end
                WAIT: begin
                    if (fifo_rd_data_valid_i) begin
                        state        <= SEND;
                        sr           <= fifo_rd_data_i;
                        idx          <= '0;
                        byte_valid_o <= 1'b1;
                        byte_last_o  <= N == 1;
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND: begin
                    if (byte_ready_i) begin
                        if (idx == LAST_IDX) begin
                            state        <= IDLE;
                            byte_valid_o <= 1'b0;
                            byte_last_o  <= 1'b0;
                            word_cnt_o   <= word_cnt_o + 16'd1;
                        end else begin
                            idx         <= idx + 1'b1;
                            sr          <= LSB_FIRST ? sr >> BYTE_WIDTH : sr << BYTE_WIDTH;
                            byte_last_o <= idx == PEN_IDX;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_byte_unpacker.sv
// tb_fifo_byte_unpacker: vector table, directed corner cases and a scoreboarded random run
// over two instances that differ only in byte order.
module tb_fifo_byte_unpacker;
    logic        clk = 0, rst = 1, empty = 1, rv = 0, ready = 1;
    logic [31:0] rd_data = 0;
    logic        a_rd, a_bv, a_last, b_rd, b_bv, b_last;
    logic [7:0]  a_byte, b_byte;
    logic [15:0] a_cnt, b_cnt;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    fifo_byte_unpacker #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .LSB_FIRST(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .fifo_empty_i(empty), .fifo_rd_en_o(a_rd),
        .fifo_rd_data_valid_i(rv), .fifo_rd_data_i(rd_data), .byte_valid_o(a_bv),
        .byte_ready_i(ready), .byte_data_o(a_byte), .byte_last_o(a_last), .word_cnt_o(a_cnt));

    fifo_byte_unpacker #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .LSB_FIRST(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .fifo_empty_i(empty), .fifo_rd_en_o(b_rd),
        .fifo_rd_data_valid_i(rv), .fifo_rd_data_i(rd_data), .byte_valid_o(b_bv),
        .byte_ready_i(ready), .byte_data_o(b_byte), .byte_last_o(b_last), .word_cnt_o(b_cnt));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic v, input logic [31:0] d, input logic r);
        empty = e; rv = v; rd_data = d; ready = r;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic e, v; logic [31:0] d; logic r;
        logic rd, bv; logic [7:0] ba, bb; logic last; logic [15:0] cnt;
    } vec_t;
    vec_t tbl[23];

    typedef struct packed {logic [7:0] b; logic l;} ent_t;
    logic [31:0] q[$];
    ent_t        ea[$], eb[$];
    int          delivered = 0;
    logic        pend_v = 0, prev_rd = 0;
    logic [31:0] pend_d = 0;

    // One cycle of the upstream FIFO model plus downstream scoreboard, evaluated at the falling edge
    task automatic cycle(input bit gen, input bit rnd_ready);
        ent_t e;
        @(negedge clk);
        rv = pend_v;
        rd_data = pend_v ? pend_d : $urandom;
        if (pend_v) begin
            delivered++;
            for (int k = 0; k < 4; k++) begin
                ea.push_back({pend_d[8*k +: 8], k == 3});
                eb.push_back({pend_d[8*(3-k) +: 8], k == 3});
            end
        end
        pend_v = 0;
        if (gen && q.size() < 4 && $urandom_range(0, 2) == 0) q.push_back($urandom);
        empty = q.size() == 0;
        if (a_rd && !empty && !(gen && $urandom_range(0, 7) == 0)) begin
            pend_v = 1;
            pend_d = q.pop_front();
        end
        ready = rnd_ready ? $urandom_range(0, 3) != 0 : 1'b1;
        chk("rd_en single pulse", {prev_rd & a_rd, a_rd & a_bv}, 0);
        prev_rd = a_rd;
        if (a_bv && ready) begin
            if (ea.size() == 0) chk("lsb unexpected byte", {a_byte, a_last}, 'x);
            else begin e = ea.pop_front(); chk("lsb byte", {a_byte, a_last}, e); end
        end
        if (b_bv && ready) begin
            if (eb.size() == 0) chk("msb unexpected byte", {b_byte, b_last}, 'x);
            else begin e = eb.pop_front(); chk("msb byte", {b_byte, b_last}, e); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //       e  v  d             r    rd bv ba     bb     last cnt
        tbl[0]  = '{1, 0, 32'h0,        1,   0, 0, 8'h00, 8'h00, 0, 0};
        tbl[1]  = '{0, 0, 32'h0,        1,   1, 0, 8'h00, 8'h00, 0, 0};
        tbl[2]  = '{1, 0, 32'h0,        1,   0, 0, 8'h00, 8'h00, 0, 0};
        tbl[3]  = '{1, 1, 32'h44332211, 1,   0, 1, 8'h11, 8'h44, 0, 0};
        tbl[4]  = '{1, 0, 32'h0,        1,   0, 1, 8'h22, 8'h33, 0, 0};
        tbl[5]  = '{1, 0, 32'h0,        0,   0, 1, 8'h22, 8'h33, 0, 0};
        tbl[6]  = '{1, 1, 32'hDEADBEEF, 0,   0, 1, 8'h22, 8'h33, 0, 0};
        tbl[7]  = '{1, 0, 32'h0,        0,   0, 1, 8'h22, 8'h33, 0, 0};
        tbl[8]  = '{1, 0, 32'h0,        0,   0, 1, 8'h22, 8'h33, 0, 0};
        tbl[9]  = '{1, 0, 32'h0,        0,   0, 1, 8'h22, 8'h33, 0, 0};
        tbl[10] = '{1, 0, 32'h0,        1,   0, 1, 8'h33, 8'h22, 0, 0};
        tbl[11] = '{1, 0, 32'h0,        1,   0, 1, 8'h44, 8'h11, 1, 0};
        tbl[12] = '{1, 0, 32'h0,        1,   0, 0, 8'h00, 8'h00, 0, 1};
        tbl[13] = '{0, 0, 32'h0,        1,   1, 0, 8'h00, 8'h00, 0, 1};
        tbl[14] = '{1, 0, 32'h0,        1,   0, 0, 8'h00, 8'h00, 0, 1};
        tbl[15] = '{1, 0, 32'h0,        1,   0, 0, 8'h00, 8'h00, 0, 1};
        tbl[16] = '{0, 0, 32'h0,        1,   1, 0, 8'h00, 8'h00, 0, 1};
        tbl[17] = '{1, 0, 32'h0,        1,   0, 0, 8'h00, 8'h00, 0, 1};
        tbl[18] = '{1, 1, 32'hAABBCCDD, 1,   0, 1, 8'hDD, 8'hAA, 0, 1};
        tbl[19] = '{1, 0, 32'h0,        1,   0, 1, 8'hCC, 8'hBB, 0, 1};
        tbl[20] = '{1, 0, 32'h0,        1,   0, 1, 8'hBB, 8'hCC, 0, 1};
        tbl[21] = '{1, 0, 32'h0,        1,   0, 1, 8'hAA, 8'hDD, 1, 1};
        tbl[22] = '{1, 0, 32'h0,        1,   0, 0, 8'h00, 8'h00, 0, 2};

        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {a_rd, a_bv, a_last, a_byte, a_cnt, b_rd, b_bv, b_last, b_byte, b_cnt}, 0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 20; i++) begin
            step(1, 0, 32'h0, 1);
            chk("empty idle", {a_rd, a_bv, b_rd, b_bv}, 0);
        end
        chk("empty word_cnt", {a_cnt, b_cnt}, 0);

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].e, tbl[i].v, tbl[i].d, tbl[i].r);
            chk($sformatf("vec%0d ctrl", i), {a_rd, a_bv, a_last, a_cnt, b_rd, b_bv, b_last, b_cnt},
                {tbl[i].rd, tbl[i].bv, tbl[i].last, tbl[i].cnt, tbl[i].rd, tbl[i].bv, tbl[i].last, tbl[i].cnt});
            if (tbl[i].bv) chk($sformatf("vec%0d bytes", i), {a_byte, b_byte}, {tbl[i].ba, tbl[i].bb});
        end

        step(0, 0, 32'h0, 1);
        step(1, 0, 32'h0, 1);
        step(1, 1, 32'h44332211, 1);
        step(1, 0, 32'h0, 1);
        step(1, 0, 32'h0, 1);
        chk("pre-reset byte", {a_bv, a_byte}, {1'b1, 8'h33});
        #2 rst = 1;
        #1;
        chk("async reset", {a_rd, a_bv, a_last, a_byte, a_cnt, b_rd, b_bv, b_last, b_byte, b_cnt}, 0);
        empty = 0;
        @(negedge clk);
        rst = 0;
        #1;
        chk("no read before edge", {a_rd, b_rd}, 0);
        @(posedge clk);
        #1;
        chk("first read after reset", {a_rd, a_bv}, 2'b10);
        step(1, 0, 32'h0, 1);
        step(1, 1, 32'h000000FF, 1);
        chk("ff byte0", {a_bv, a_byte, a_last, b_byte}, {1'b1, 8'hFF, 1'b0, 8'h00});
        step(1, 0, 32'h0, 1);
        chk("ff byte1", {a_bv, a_byte, a_last, b_byte}, {1'b1, 8'h00, 1'b0, 8'h00});
        step(1, 0, 32'h0, 1);
        chk("ff byte2", {a_bv, a_byte, a_last, b_byte}, {1'b1, 8'h00, 1'b0, 8'h00});
        step(1, 0, 32'h0, 1);
        chk("ff byte3", {a_bv, a_byte, a_last, b_byte}, {1'b1, 8'h00, 1'b1, 8'hFF});
        step(1, 0, 32'h0, 1);
        chk("ff word_cnt", {a_bv, a_cnt, b_cnt}, {1'b0, 16'd1, 16'd1});

        delivered = 1;
        q.push_back(32'hAABBCCDD);
        q.push_back(32'h01020304);
        for (int i = 0; i < 3000; i++) cycle(1, 1);
        for (int n = 0; n < 400 && (q.size() != 0 || ea.size() != 0 || eb.size() != 0 || pend_v); n++) cycle(0, 0);
        chk("drain complete", {q.size() == 0, ea.size() == 0, eb.size() == 0, pend_v}, 4'b1110);
        cycle(0, 0);
        cycle(0, 0);
        chk("random word_cnt", {a_cnt, b_cnt}, {delivered[15:0], delivered[15:0]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_byte_unpacker.md
FIFO_BYTE_UNPACKER -- requirements
Module: fifo_byte_unpacker

Interface
REQ-001 Parameter DATA_WIDTH, default 32, FIFO word width; SHALL be a multiple of BYTE_WIDTH.
REQ-002 Parameter BYTE_WIDTH, default 8, output symbol width.
REQ-003 Parameter LSB_FIRST, default 1, byte order (1: bits [7:0] first; 0: MSB byte first).
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous assert, active-high.
REQ-006 fifo_empty_i  input  1  upstream sync_fifo empty flag.
REQ-007 fifo_rd_en_o  output  1  read request to upstream sync_fifo.
REQ-008 fifo_rd_data_valid_i  input  1  upstream read data valid, one cycle after accepted rd_en.
REQ-009 fifo_rd_data_i  input  DATA_WIDTH  upstream read data.
REQ-010 byte_valid_o  output  1  output byte valid.
REQ-011 byte_ready_i  input  1  downstream ready.
REQ-012 byte_data_o  output  BYTE_WIDTH  output byte.
REQ-013 byte_last_o  output  1  current byte is the final byte of its word.
REQ-014 word_cnt_o  output  16  count of words fully drained, wraps at 2^16.

Function
REQ-015 The block SHALL implement states IDLE, REQ, WAIT and SEND.
REQ-016 IDLE: fifo_empty_i=0 -> REQ next cycle; fifo_empty_i=1 -> stay IDLE.
REQ-017 REQ: fifo_rd_en_o SHALL be 1 for exactly this one cycle, decoded from registered state only, then -> WAIT.
REQ-018 fifo_rd_en_o SHALL be 0 in every state other than REQ.
REQ-019 WAIT, fifo_rd_data_valid_i=1: load fifo_rd_data_i into the shift register, clear the byte index, -> SEND.
REQ-020 WAIT, fifo_rd_data_valid_i=0: discard the cycle, no counter change, -> IDLE.
REQ-021 SEND: byte_valid_o=1; byte_data_o is the byte at the current index in LSB_FIRST order.
REQ-022 Byte advance occurs only on byte_valid_o and byte_ready_i both 1 in the same cycle.
REQ-023 With byte_ready_i=0, byte_data_o and byte_last_o SHALL hold stable and byte_valid_o SHALL stay 1.
REQ-024 byte_last_o SHALL be 1 only in SEND while index = DATA_WIDTH/BYTE_WIDTH-1.
REQ-025 On handshake of the last byte: word_cnt_o increments by 1 (modulo 2^16), -> IDLE.
REQ-026 byte_valid_o and byte_last_o SHALL be 0 in IDLE, REQ and WAIT.
REQ-027 Per-word minimum latency: 3 cycles (IDLE, REQ, WAIT) before the first byte, then one byte per cycle under continuous ready.
REQ-028 No new FIFO read SHALL be issued while a word is held; at most one word in flight.
REQ-029 fifo_rd_data_valid_i outside WAIT SHALL be ignored.

Reset
REQ-030 Assertion of rst_i SHALL immediately force state IDLE, fifo_rd_en_o=0, byte_valid_o=0, byte_last_o=0, byte_data_o=0, byte index 0, shift register 0, word_cnt_o=0.
REQ-031 Reset asserted mid-word SHALL discard the held word and its remaining bytes, with no word_cnt_o increment.
REQ-032 After rst_i deasserts, the first FIFO read SHALL occur no earlier than the first rising edge following deassertion.

Verification
REQ-033 Empty FIFO held 20 cycles -> fifo_rd_en_o never 1, byte_valid_o never 1, word_cnt_o=0.
REQ-034 Push 0x44332211, byte_ready_i=1, LSB_FIRST=1 -> bytes 0x11,0x22,0x33,0x44 on consecutive cycles, byte_last_o only with 0x44, word_cnt_o=1.
REQ-035 Push 0x44332211 with LSB_FIRST=0 -> bytes 0x44,0x33,0x22,0x11; push 0xAABBCCDD and 0x01020304 back-to-back -> 8 bytes in FIFO order, single-cycle fifo_rd_en_o pulses, word_cnt_o=2.
REQ-036 byte_ready_i=0 for 5 cycles on the second byte -> 0x22 held stable with valid=1, then transfer resumes with no loss or duplication.
REQ-037 rst_i pulsed after byte 0x22 accepted -> all outputs 0 asynchronously, word_cnt_o=0; next pushed word 0x0000_00FF drains fully from byte 0xFF.
REQ-038 Force fifo_rd_data_valid_i=0 in WAIT -> return to IDLE, no byte output, word_cnt_o unchanged.
